// File: rtl/adder_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer.
//   NIBBLE_W    : width of one slice of the shared adder datapath
//   seq_state_t : controller states (IDLE, RUN, DONE)
package adder_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/adder.sv
// Existing 4-bit adder slice, purely combinational.
// Ports:
//   a, b  : 4-bit addends
//   c_in  : carry in
//   sum   : 4-bit sum
//   c_out : carry out of bit 3
module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, c_in};

endmodule

// File: rtl/adder_seq.sv
// Multi-precision add/subtract sequencer. One 4-bit adder slice is reused
// over NIBBLES cycles, LSB nibble first, with a registered carry chain.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operand handshake (ready only in IDLE)
//   a, b, c_in, op_sub   : operands, carry-in (add only), 1 = A-B
//   out_valid / out_ready: result handshake (valid only in DONE)
//   sum, c_out, ovf      : W-bit result, final carry, signed overflow
//
// state | meaning
// IDLE  | waiting for an operand request
// RUN   | one nibble processed per cycle
// DONE  | result held until the consumer takes it
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b,
  input  logic                          c_in,
  input  logic                          op_sub,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]   sum,
  output logic                          c_out,
  output logic                          ovf
);

  localparam int IDX_W = $clog2(NIBBLES);

  seq_state_t state_q, state_d;

  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_q, b_q, res_q;
  logic [IDX_W-1:0]                 idx_q;
  logic                             carry_q;
  logic                             ovf_q;

  logic [NIBBLE_W-1:0] slice_a, slice_b, slice_sum;
  logic                slice_cout;
  logic                last_nibble;

  assign slice_a     = a_q[idx_q];
  assign slice_b     = b_q[idx_q];
  assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));

  adder u_adder (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)    state_d = RUN;
      RUN:     if (last_nibble) state_d = DONE;
      DONE:    if (out_ready)   state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Subtraction is folded into the operand latch: B is stored inverted and
  // the carry register is seeded with 1, so RUN only ever adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= op_sub ? ~b : b;
            carry_q <= op_sub ? 1'b1 : c_in;
            idx_q   <= '0;
          end
        end
        RUN: begin
          res_q[idx_q] <= slice_sum;
          carry_q      <= slice_cout;
          idx_q        <= last_nibble ? '0 : idx_q + IDX_W'(1);
          // Signed overflow: both addends share a sign the MSB result lacks,
          // equivalent to carry-into-MSB XOR carry-out-of-MSB.
          if (last_nibble)
            ovf_q <= (slice_a[NIBBLE_W-1] == slice_b[NIBBLE_W-1]) &&
                     (slice_sum[NIBBLE_W-1] != slice_a[NIBBLE_W-1]);
        end
        default: ;
      endcase
    end
  end

  assign sum   = res_q;
  assign c_out = carry_q;
  assign ovf   = ovf_q;

endmodule

// File: doc/adder_seq.md
# adder_seq

Multi-precision add/subtract sequencer that reuses a single 4-bit `adder` slice over several cycles to combine operands of `NIBBLES`×4 bits. Operands enter through a valid/ready handshake, the block walks the nibbles LSB-first with a registered carry chain, and the result is held under a second valid/ready handshake. It sits between a requester (bench or host FSM) and the existing 4-bit adder datapath. It is the sequencing controller for that datapath.

## Interface
- `NIBBLES`, default 4: operand width in nibbles; W = 4·NIBBLES; legal range 2..16.
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `a`  in  W  operand A.
- `b`  in  W  operand B.
- `c_in`  in  1  carry-in; used for add only, ignored for subtract.
- `op_sub`  in  1  0 = A+B+c_in, 1 = A−B (A + ~B + 1).
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer takes result.
- `sum`  out  W  result.
- `c_out`  out  1  final carry; for subtract, 1 = no borrow.
- `ovf`  out  1  two's-complement signed overflow of the W-bit result.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: `in_ready`=1. On `in_valid`: latch `a`, latch `b` (inverted if `op_sub`), latch `op_sub`. Set the carry register to `op_sub ? 1 : c_in`. Clear the nibble index. Go to RUN.
- RUN: slice inputs are nibble[idx] of A, nibble[idx] of B', and the carry register. Each cycle, write the slice `sum` into result nibble[idx], load the slice `c_out` into the carry register, and increment idx. When idx = NIBBLES−1 is processed, go to DONE.
- `ovf` = carry into MSB XOR carry out of MSB. It is captured on the last RUN cycle.
- DONE: `out_valid`=1. `sum`, `c_out` and `ovf` are stable while `out_ready`=0. On `out_ready`=1, go to IDLE.
- `in_valid` is ignored outside IDLE. Operand inputs are don't-care except on the accept edge.
- Result register is not cleared between operations. Nibbles are overwritten during RUN. `sum` is only meaningful while `out_valid`=1.
- Reset, asynchronous at any time including mid-RUN or in DONE: state=IDLE, idx=0, carry=0, result=0, `ovf`=0. Any in-flight operation is discarded.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `sum`=0, `c_out`=0, `ovf`=0.
- Accept at edge E0. RUN occupies edges E1..E(NIBBLES). `out_valid` rises after edge E(NIBBLES), i.e. latency NIBBLES cycles (4 cycles by default).
- `in_ready` falls the cycle after accept. It returns the cycle after the DONE handshake edge. No back-to-back acceptance.
- Peak throughput is one operation per NIBBLES+2 cycles.
- Slice path (adder plus nibble muxes) is combinational within one cycle. All outputs are registered or decoded from the state register. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Package `adder_seq_pkg`: `NIBBLE_W`=4 and a state enum type `seq_state_t` {IDLE, RUN, DONE}.
- One sub-module: a single instance of the existing 4-bit `adder`, with ports (a, b, c_in, c_out, sum). No other arithmetic in the controller except the idx increment.
- idx width is $clog2(NIBBLES).

## Test plan
- Add 0x1234 + 0x4321, `c_in`=0 → `sum`=0x5555, `c_out`=0, `ovf`=0. `out_valid` rises exactly 4 cycles after the accept edge.
- Add 0xFFFF + 0x0000, `c_in`=1 → `sum`=0x0000, `c_out`=1. The carry ripples across all nibble cycles.
- Subtract 0x0005 − 0x0007 → `sum`=0xFFFE, `c_out`=0 (borrow), `ovf`=0. Subtract 0x8000 − 0x0001 → `sum`=0x7FFF, `c_out`=1, `ovf`=1.
- Add 0x7FFF + 0x0001, `c_in`=0 → `sum`=0x8000, `ovf`=1. Then hold `out_ready`=0 for 3 cycles while pulsing `in_valid` → outputs stable, `in_ready`=0, no new operation accepted.
- Assert `rst_n`=0 on the second RUN cycle → all outputs at reset values immediately. After release, 0x0F0F + 0x00F1 → `sum`=0x1000, `c_out`=0.
- Random: 200 operations with random `op_sub`/`c_in` and random `out_ready` stalls → each result equals the W-bit reference model including `c_out`/`ovf`, in order and exactly once.
